// File: rtl/icache_pkg.sv
// icache_pkg: shared constants for the instruction cache.
//   - default geometry (lines, words per line, significant address bits)
//   - FSM state encodings
//   - bus word type
package icache_pkg;

  localparam int unsigned IcacheLineNum = 16;
  localparam int unsigned IcacheWords   = 4;
  localparam int unsigned IcacheAddrUsed = 18;

  typedef logic [31:0] data_bus_t;

  localparam logic [1:0] StBoot = 2'd0;
  localparam logic [1:0] StIdle = 2'd1;
  localparam logic [1:0] StFill = 2'd2;
  localparam logic [1:0] StResp = 2'd3;

endpackage

// File: rtl/icache_if.sv
// icache_if: fetcher handshake plus memory-controller read bus.
//   slave  modport: the cache side (takes addr/rn and mem_data/mem_valid,
//                   drives Inst/Read_ready and mem_req/mem_addr)
//   master modport: the environment side (fetcher + memory controller)
interface icache_if;
  import icache_pkg::*;

  data_bus_t addr;
  logic      rn;
  data_bus_t Inst;
  logic      Read_ready;
  logic      mem_req;
  data_bus_t mem_addr;
  data_bus_t mem_data;
  logic      mem_valid;

  modport slave (
    input  addr, rn, mem_data, mem_valid,
    output Inst, Read_ready, mem_req, mem_addr
  );

  modport master (
    output addr, rn, mem_data, mem_valid,
    input  Inst, Read_ready, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_line_ram.sv
// icache_line_ram: valid/tag/data storage for a direct-mapped cache.
//   clk, rst    : clock, async active-high reset (clears valid bits only)
//   rd_idx_i    : combinational read index -> rd_valid_o, rd_tag_o, rd_line_o
//   we_i        : full-line write of wr_line_i / wr_tag_i at wr_idx_i, sets valid
module icache_line_ram #(
  parameter int unsigned LINE_NUM       = 16,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned TAG_W          = 10,
  localparam int unsigned IdxW          = $clog2(LINE_NUM)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [IdxW-1:0]                      rd_idx_i,
  output logic                                 rd_valid_o,
  output logic [TAG_W-1:0]                     rd_tag_o,
  output logic [WORDS_PER_LINE-1:0][31:0]      rd_line_o,
  input  logic                                 we_i,
  input  logic [IdxW-1:0]                      wr_idx_i,
  input  logic [TAG_W-1:0]                     wr_tag_i,
  input  logic [WORDS_PER_LINE-1:0][31:0]      wr_line_i
);

  logic [LINE_NUM-1:0]                valid_q;
  logic [TAG_W-1:0]                   tag_q  [LINE_NUM];
  logic [WORDS_PER_LINE-1:0][31:0]    data_q [LINE_NUM];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and data need no reset: they are only read qualified by valid.
  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_line_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_line_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache.sv
// icache: direct-mapped, blocking instruction cache.
//   clk, rst : clock, async active-high reset
//   rdy      : global ready; when low, every register and the arrays hold
//   bus      : icache_if.slave -- fetcher addr/rn -> Inst/Read_ready, and
//              line refill via mem_req/mem_addr <- mem_data/mem_valid
module icache
  import icache_pkg::*;
#(
  parameter int unsigned LINE_NUM       = IcacheLineNum,
  parameter int unsigned WORDS_PER_LINE = IcacheWords,
  parameter int unsigned ADDR_USED      = IcacheAddrUsed
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     rdy,
  icache_if.slave  bus
);

  localparam int unsigned OffW   = $clog2(WORDS_PER_LINE);
  localparam int unsigned IdxW   = $clog2(LINE_NUM);
  localparam int unsigned IdxLsb = OffW + 2;
  localparam int unsigned TagLsb = IdxLsb + IdxW;
  localparam int unsigned TagW   = ADDR_USED - TagLsb;

  logic [1:0]                        state_q, state_d;
  logic [OffW-1:0]                   cnt_q, cnt_d;
  logic [OffW-1:0]                   off_q, off_d;
  logic [IdxW-1:0]                   idx_q, idx_d;
  logic [TagW-1:0]                   tag_q, tag_d;
  logic [WORDS_PER_LINE-1:0][31:0]   line_buf_q, line_buf_d;
  data_bus_t                         inst_q, inst_d;
  logic                              read_ready_q, read_ready_d;
  logic                              mem_req_q, mem_req_d;
  data_bus_t                         mem_addr_q, mem_addr_d;

  data_bus_t                         lk_addr;
  logic [OffW-1:0]                   lk_off;
  logic [IdxW-1:0]                   lk_idx;
  logic [TagW-1:0]                   lk_tag;
  logic                              rd_valid;
  logic [TagW-1:0]                   rd_tag;
  logic [WORDS_PER_LINE-1:0][31:0]   rd_line;
  logic                              hit;
  logic                              ram_we;
  logic [WORDS_PER_LINE-1:0][31:0]   wr_line;
  logic                              unused_addr_bits;

  // The boot lookup targets address 0 independent of the fetcher.
  assign lk_addr = (state_q == StBoot) ? '0 : bus.addr;
  assign lk_off  = lk_addr[IdxLsb-1:2];
  assign lk_idx  = lk_addr[TagLsb-1:IdxLsb];
  assign lk_tag  = lk_addr[ADDR_USED-1:TagLsb];
  assign hit     = rd_valid && (rd_tag == lk_tag);
  assign unused_addr_bits = ^lk_addr[1:0];

  // Completed line: buffered words plus the last word straight off the bus.
  always_comb begin
    wr_line = line_buf_q;
    wr_line[WORDS_PER_LINE-1] = bus.mem_data;
  end

  icache_line_ram #(
    .LINE_NUM       (LINE_NUM),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .TAG_W          (TagW)
  ) u_line_ram (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (lk_idx),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_line_o  (rd_line),
    .we_i       (ram_we),
    .wr_idx_i   (idx_q),
    .wr_tag_i   (tag_q),
    .wr_line_i  (wr_line)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    off_d        = off_q;
    idx_d        = idx_q;
    tag_d        = tag_q;
    line_buf_d   = line_buf_q;
    inst_d       = inst_q;
    read_ready_d = read_ready_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    ram_we       = 1'b0;
    if (rdy) begin
      unique case (state_q)
        StBoot, StIdle: begin
          if (state_q == StBoot || bus.rn) begin
            if (hit) begin
              read_ready_d = 1'b1;
              inst_d       = rd_line[lk_off];
              state_d      = StResp;
            end else begin
              off_d      = lk_off;
              idx_d      = lk_idx;
              tag_d      = lk_tag;
              cnt_d      = '0;
              mem_req_d  = 1'b1;
              mem_addr_d = {lk_addr[31:IdxLsb], {IdxLsb{1'b0}}};
              state_d    = StFill;
            end
          end
        end
        StFill: begin
          if (bus.mem_valid) begin
            line_buf_d[cnt_q] = bus.mem_data;
            if (cnt_q == OffW'(WORDS_PER_LINE - 1)) begin
              ram_we       = 1'b1;
              mem_req_d    = 1'b0;
              read_ready_d = 1'b1;
              inst_d       = wr_line[off_q];
              state_d      = StResp;
            end else begin
              cnt_d      = cnt_q + 1'b1;
              mem_addr_d = mem_addr_q + 32'd4;
            end
          end
        end
        StResp: begin
          read_ready_d = 1'b0;
          state_d      = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StBoot;
      cnt_q        <= '0;
      off_q        <= '0;
      idx_q        <= '0;
      tag_q        <= '0;
      line_buf_q   <= '0;
      inst_q       <= '0;
      read_ready_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      off_q        <= off_d;
      idx_q        <= idx_d;
      tag_q        <= tag_d;
      line_buf_q   <= line_buf_d;
      inst_q       <= inst_d;
      read_ready_q <= read_ready_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  assign bus.Inst       = inst_q;
  assign bus.Read_ready = read_ready_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_icache.sv
// tb_icache: directed bench for icache with a small memory-controller model.
module tb_icache;

  localparam int MemLat = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b0;

  icache_if ifc ();

  icache dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory model: data = mem_base (+ byte offset within line when mem_inc).
  logic [31:0] mem_base = 32'h0000_0013;
  logic        mem_inc  = 1'b0;
  logic        consumed;
  int          wait_c   = 0;
  logic [31:0] log_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return mem_base + (mem_inc ? {28'h0, a[3:0]} : 32'h0);
  endfunction

  function automatic logic [31:0] log_at(input int i);
    if (i < log_q.size()) return log_q[i];
    return 32'hDEAD_BEEF;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      consumed <= 1'b0;
    end else begin
      consumed <= ifc.mem_valid && rdy && ifc.mem_req;
      if (ifc.mem_valid && rdy && ifc.mem_req) log_q.push_back(ifc.mem_addr);
    end
  end

  always @(negedge clk) begin
    if (rst || !ifc.mem_req) begin
      wait_c = 0;
      ifc.mem_valid = 1'b0;
      ifc.mem_data  = 32'h0;
    end else if (consumed) begin
      wait_c = 0;
      ifc.mem_valid = 1'b0;
    end else if (rdy && !ifc.mem_valid) begin
      if (wait_c == MemLat - 1) begin
        ifc.mem_valid = 1'b1;
        ifc.mem_data  = mem_word(ifc.mem_addr);
      end else begin
        wait_c++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits for Read_ready; n counts edges from the call up to the pulse.
  task automatic wait_rr(input int maxc, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ifc.Read_ready && n < maxc);
  endtask

  // Steps out of RESP into IDLE, then issues one fetch and waits for it.
  task automatic fetch(input logic [31:0] a, output int n);
    @(posedge clk); #1;
    ifc.addr = a;
    ifc.rn   = 1'b1;
    wait_rr(80, n);
    ifc.rn   = 1'b0;
  endtask

  initial begin
    int n;
    int base;
    logic [31:0] held;
    ifc.addr = 32'h0;
    ifc.rn   = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_read_ready", {31'h0, ifc.Read_ready}, 32'h0);
    chk("rst_inst", ifc.Inst, 32'h0);
    chk("rst_mem_req", {31'h0, ifc.mem_req}, 32'h0);
    chk("rst_mem_addr", ifc.mem_addr, 32'h0);

    // Boot stays frozen while rdy is low
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("boot_frozen_req", {31'h0, ifc.mem_req}, 32'h0);

    // Boot fill of line 0 without rn
    rdy = 1'b1;
    wait_rr(60, n);
    chk("boot_rr", {31'h0, ifc.Read_ready}, 32'h1);
    chk("boot_inst", ifc.Inst, 32'h0000_0013);
    chk("boot_nreq", log_q.size(), 4);
    for (int i = 0; i < 4; i++) chk("boot_addr", log_at(i), 32'(i * 4));

    // Hit at 0x8: one cycle, no memory traffic, single-cycle pulse
    base = log_q.size();
    fetch(32'h8, n);
    chk("hit8_latency", n, 1);
    chk("hit8_inst", ifc.Inst, 32'h0000_0013);
    chk("hit8_noreq", {31'h0, ifc.mem_req}, 32'h0);
    @(posedge clk); #1;
    chk("rr_pulse", {31'h0, ifc.Read_ready}, 32'h0);
    chk("hit8_nolog", log_q.size(), base);

    // Miss on last word: bypass from mem_data
    mem_base = 32'hAAAA_0000;
    mem_inc  = 1'b1;
    base = log_q.size();
    fetch(32'h10C, n);
    chk("miss10c_slow", {31'h0, n > 1}, 32'h1);
    chk("miss10c_inst", ifc.Inst, 32'hAAAA_000C);
    chk("miss10c_nreq", log_q.size(), base + 4);
    chk("miss10c_first", log_at(base), 32'h100);
    chk("miss10c_last", log_at(base + 3), 32'h10C);

    // Hit in the freshly filled line from the buffered path
    fetch(32'h104, n);
    chk("hit104_latency", n, 1);
    chk("hit104_inst", ifc.Inst, 32'hAAAA_0004);

    // Index conflict: 0x040 and 0x440 share index 4
    mem_base = 32'h1111_0000;
    base = log_q.size();
    fetch(32'h040, n);
    chk("c040_inst", ifc.Inst, 32'h1111_0000);
    chk("c040_nreq", log_q.size(), base + 4);
    mem_base = 32'h4444_0000;
    base = log_q.size();
    fetch(32'h440, n);
    chk("c440_inst", ifc.Inst, 32'h4444_0000);
    chk("c440_first", log_at(base), 32'h440);
    mem_base = 32'h5555_0000;
    base = log_q.size();
    fetch(32'h048, n);
    chk("c048_inst", ifc.Inst, 32'h5555_0008);
    chk("c048_refill", log_q.size(), base + 4);

    // rdy low for 3 cycles mid-fill with mem_valid held high
    mem_base = 32'h6666_0000;
    base = log_q.size();
    @(posedge clk); #1;
    ifc.addr = 32'h084;
    ifc.rn   = 1'b1;
    for (int i = 0; i < 40 && log_q.size() < base + 1; i++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 10 && !ifc.mem_valid; i++) begin
      @(posedge clk); #1;
    end
    chk("stall_valid_seen", {31'h0, ifc.mem_valid}, 32'h1);
    rdy  = 1'b0;
    held = ifc.mem_addr;
    chk("stall_addr_word1", held, 32'h084);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_addr", ifc.mem_addr, held);
      chk("stall_nlog", log_q.size(), base + 1);
    end
    rdy = 1'b1;
    wait_rr(60, n);
    ifc.rn = 1'b0;
    chk("stall_rr", {31'h0, ifc.Read_ready}, 32'h1);
    chk("stall_inst", ifc.Inst, 32'h6666_0004);
    chk("stall_nreq", log_q.size(), base + 4);
    chk("stall_last", log_at(base + 3), 32'h08C);

    // Async reset in the middle of a fill (cnt=2)
    mem_base = 32'h0000_0013;
    mem_inc  = 1'b0;
    base = log_q.size();
    @(posedge clk); #1;
    ifc.addr = 32'h200;
    ifc.rn   = 1'b1;
    for (int i = 0; i < 40 && log_q.size() < base + 2; i++) begin
      @(posedge clk); #1;
    end
    chk("arst_two_words", log_q.size(), base + 2);
    #2 rst = 1'b1;
    #1;
    ifc.rn = 1'b0;
    chk("arst_mem_req", {31'h0, ifc.mem_req}, 32'h0);
    chk("arst_mem_addr", ifc.mem_addr, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    base = log_q.size();
    wait_rr(60, n);
    chk("reboot_inst", ifc.Inst, 32'h0000_0013);
    chk("reboot_first", log_at(base), 32'h0);
    mem_base = 32'h7777_0000;
    mem_inc  = 1'b1;
    base = log_q.size();
    fetch(32'h208, n);
    chk("arst_refill_inst", ifc.Inst, 32'h7777_0008);
    chk("arst_refill_nreq", log_q.size(), base + 4);
    chk("arst_refill_first", log_at(base), 32'h200);
    fetch(32'h20C, n);
    chk("hit20c_latency", n, 1);
    chk("hit20c_inst", ifc.Inst, 32'h7777_000C);

    // Bits above ADDR_USED alias onto the same line
    base = log_q.size();
    fetch(32'h0004_0204, n);
    chk("alias_latency", n, 1);
    chk("alias_inst", ifc.Inst, 32'h7777_0004);
    chk("alias_nolog", log_q.size(), base);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
